// File: rtl/prbs_pattern_gen.sv
// Internal test-data generator: static, alternating, PRBS7..31 or user-word streams,
// DATA_W bits per data_clock rising edge, with error injection, inversion and origin marker.
module prbs_pattern_gen #(
    parameter int          DATA_W = 1,
    parameter logic [30:0] SEED   = 31'h7FFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_clock,
    input  logic              enable,
    input  logic [3:0]        dat_pat,
    input  logic [15:0]       user_pat,
    input  logic              invert,
    input  logic              err_inj,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              seq_start,
    output logic [30:0]       lfsr_state
);

    logic [30:0]       lfsr_q, lfsr_d;
    logic [3:0]        ptr_q, ptr_d;
    logic              phase_q, phase_d;
    logic              pend_q, pend_d;
    logic              dclk_q, dclk_d;
    logic              guard_q, guard_d;
    logic [3:0]        pat_q, pat_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              sstart_q, sstart_d;

    logic [4:0]        len, tap_a, tap_b;
    logic [30:0]       mask;
    logic              is_prbs;

    logic              stb, pat_chg, seq_hit, fb;
    logic [30:0]       lfsr_cur, s_w;
    logic [3:0]        ptr_cur;
    logic              phase_cur, pend_cur;
    logic [DATA_W-1:0] prbs_word, alt_word, user_word, gen_word, inj_word;

    // Modes 0-2, 8 and 9-15 fall back to PRBS7 geometry; only PRBS modes use it.
    always_comb begin
        len   = 5'd7;
        tap_b = 5'd6;
        case (dat_pat)
            4'd4:    begin len = 5'd9;  tap_b = 5'd5;  end
            4'd5:    begin len = 5'd15; tap_b = 5'd14; end
            4'd6:    begin len = 5'd23; tap_b = 5'd18; end
            4'd7:    begin len = 5'd31; tap_b = 5'd28; end
            default: begin len = 5'd7;  tap_b = 5'd6;  end
        endcase
        tap_a   = len;
        mask    = ~(31'h7FFFFFFF << len);
        is_prbs = (dat_pat >= 4'd3) && (dat_pat != 4'd8);
    end

    always_comb begin
        pat_chg   = (dat_pat != pat_q);
        // guard_q blocks a data_clock that was already high when reset was released
        stb       = data_clock & ~dclk_q & enable & ~guard_q;

        lfsr_cur  = lfsr_q;
        ptr_cur   = ptr_q;
        phase_cur = phase_q;
        pend_cur  = pend_q;
        if (pat_chg) begin
            lfsr_cur  = SEED;
            ptr_cur   = 4'd0;
            phase_cur = 1'b0;
            pend_cur  = 1'b0;
        end else if (is_prbs && ((lfsr_q & mask) == 31'd0)) begin
            lfsr_cur  = SEED;
        end
        pend_cur = pend_cur | err_inj;

        s_w       = lfsr_cur & mask;
        fb        = 1'b0;
        prbs_word = '0;
        alt_word  = '0;
        user_word = '0;
        for (int k = 0; k < DATA_W; k++) begin
            fb                      = s_w[tap_a - 5'd1] ^ s_w[tap_b - 5'd1];
            prbs_word[DATA_W-1-k]   = fb;
            s_w                     = {s_w[29:0], fb} & mask;
            alt_word[DATA_W-1-k]    = ~(phase_cur ^ k[0]);
            user_word[DATA_W-1-k]   = user_pat[4'd15 - (ptr_cur + k[3:0])];
        end

        case (dat_pat)
            4'd0:    begin gen_word = '0;        seq_hit = 1'b1; end
            4'd1:    begin gen_word = '1;        seq_hit = 1'b1; end
            4'd2:    begin gen_word = alt_word;  seq_hit = 1'b1; end
            4'd8:    begin gen_word = user_word; seq_hit = (ptr_cur == 4'd0); end
            default: begin gen_word = prbs_word; seq_hit = ((lfsr_cur & mask) == (SEED & mask)); end
        endcase
        inj_word            = gen_word;
        inj_word[DATA_W-1]  = gen_word[DATA_W-1] ^ pend_cur;

        lfsr_d     = lfsr_cur;
        ptr_d      = ptr_cur;
        phase_d    = phase_cur;
        pend_d     = pend_cur;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        sstart_d   = 1'b0;
        dclk_d     = data_clock;
        guard_d    = guard_q & data_clock;
        pat_d      = dat_pat;
        if (stb) begin
            data_out_d = inj_word ^ {DATA_W{invert}};
            valid_d    = 1'b1;
            sstart_d   = seq_hit;
            pend_d     = 1'b0;
            if (is_prbs)
                lfsr_d = s_w;
            if (dat_pat == 4'd8)
                ptr_d = ptr_cur + 4'(DATA_W);
            if (dat_pat == 4'd2)
                phase_d = phase_cur ^ 1'(DATA_W % 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= SEED;
            ptr_q      <= 4'd0;
            phase_q    <= 1'b0;
            pend_q     <= 1'b0;
            dclk_q     <= 1'b0;
            guard_q    <= data_clock;
            pat_q      <= dat_pat;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            sstart_q   <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            ptr_q      <= ptr_d;
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            dclk_q     <= dclk_d;
            guard_q    <= guard_d;
            pat_q      <= pat_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            sstart_q   <= sstart_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign seq_start  = sstart_q;
    assign lfsr_state = lfsr_q & mask;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Self-checking bench for prbs_pattern_gen: three widths (1, 4, 8) share stimulus and are
// compared against a sequence-level reference model of the pattern rules.
module tb_prbs_pattern_gen;

    localparam int NB = 4096;

    logic        clk = 1'b0;
    logic        rst, data_clock, enable, invert, err_inj;
    logic [3:0]  dat_pat;
    logic [15:0] user_pat;

    logic [0:0]  out1;
    logic [3:0]  out4;
    logic [7:0]  out8;
    logic        v1, v4, v8, s1, s4, s8;
    logic [30:0] l1, l4, l8;

    always #5 clk = ~clk;

    prbs_pattern_gen #(.DATA_W(1)) u_w1 (.clk(clk), .rst(rst), .data_clock(data_clock), .enable(enable),
        .dat_pat(dat_pat), .user_pat(user_pat), .invert(invert), .err_inj(err_inj),
        .data_out(out1), .data_valid(v1), .seq_start(s1), .lfsr_state(l1));
    prbs_pattern_gen #(.DATA_W(4)) u_w4 (.clk(clk), .rst(rst), .data_clock(data_clock), .enable(enable),
        .dat_pat(dat_pat), .user_pat(user_pat), .invert(invert), .err_inj(err_inj),
        .data_out(out4), .data_valid(v4), .seq_start(s4), .lfsr_state(l4));
    prbs_pattern_gen #(.DATA_W(8)) u_w8 (.clk(clk), .rst(rst), .data_clock(data_clock), .enable(enable),
        .dat_pat(dat_pat), .user_pat(user_pat), .invert(invert), .err_inj(err_inj),
        .data_out(out8), .data_valid(v8), .seq_start(s8), .lfsr_state(l8));

    logic [12:0] act_out;
    logic [5:0]  act_vs;
    logic [92:0] act_lfsr;
    assign act_out  = {out8, out4, out1};
    assign act_vs   = {v8, v4, v1, s8, s4, s1};
    assign act_lfsr = {l8, l4, l1};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference sequences for the five PRBS lengths, seeded all ones.
    bit prbs_seq [5][NB];

    int          m_cnt;
    bit          m_pend, m_prev, m_guard;
    logic [3:0]  m_pat;
    logic [31:0] e_out [3];
    bit          e_valid;
    bit          e_ss [3];
    int          widths [3] = '{1, 4, 8};
    logic [12:0] exp_out;
    logic [5:0]  exp_vs;

    function automatic int li_of(logic [3:0] mode);
        case (mode)
            4'd4: return 1;
            4'd5: return 2;
            4'd6: return 3;
            4'd7: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int len_of(int li);
        case (li)
            1: return 9;
            2: return 15;
            3: return 23;
            4: return 31;
            default: return 7;
        endcase
    endfunction

    function automatic int tapb_of(int li);
        case (li)
            1: return 5;
            2: return 14;
            3: return 18;
            4: return 28;
            default: return 6;
        endcase
    endfunction

    function automatic bit hist(int li, int m);
        if (m < 0) return 1'b1;
        if (m >= NB) return 1'b0;
        return prbs_seq[li][m];
    endfunction

    task automatic init_prbs();
        for (int li = 0; li < 5; li++)
            for (int n = 0; n < NB; n++)
                prbs_seq[li][n] = hist(li, n - len_of(li)) ^ hist(li, n - tapb_of(li));
    endtask

    function automatic logic [31:0] model_word(int w, logic [3:0] mode, int cnt, logic [15:0] up);
        logic [31:0] r;
        int li;
        r  = '0;
        li = li_of(mode);
        for (int k = 0; k < w; k++) begin
            int m;
            bit b;
            m = cnt * w + k;
            case (mode)
                4'd0:    b = 1'b0;
                4'd1:    b = 1'b1;
                4'd2:    b = (m % 2 == 0);
                4'd8:    b = up[15 - (m % 16)];
                default: b = hist(li, m);
            endcase
            r[w-1-k] = b;
        end
        return r;
    endfunction

    function automatic bit model_ss(int w, logic [3:0] mode, int cnt);
        longint period;
        if (mode <= 4'd2) return 1'b1;
        if (mode == 4'd8) return ((cnt * w) % 16 == 0);
        period = (64'd1 << len_of(li_of(mode))) - 1;
        return (longint'(cnt * w) % period == 0);
    endfunction

    function automatic logic [30:0] model_lfsr(int w, logic [3:0] mode, int cnt);
        logic [30:0] r;
        int li, n;
        r  = '0;
        li = li_of(mode);
        n  = cnt * w;
        for (int i = 0; i < len_of(li); i++)
            r[i] = hist(li, n - 1 - i);
        return r;
    endfunction

    // Advance one clk: update the model from the inputs seen at this edge, then settle.
    task automatic cycle();
        bit stb;
        logic [31:0] word;
        @(posedge clk);
        if (rst) begin
            m_cnt   = 0;
            m_pend  = 1'b0;
            m_prev  = 1'b0;
            m_guard = data_clock;
            m_pat   = dat_pat;
            e_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                e_out[i] = '0;
                e_ss[i]  = 1'b0;
            end
        end else begin
            stb = data_clock && !m_prev && enable && !m_guard;
            if (dat_pat != m_pat) begin
                m_cnt  = 0;
                m_pend = 1'b0;
            end
            if (err_inj) m_pend = 1'b1;
            e_valid = stb;
            for (int i = 0; i < 3; i++) begin
                e_ss[i] = 1'b0;
                if (stb) begin
                    word = model_word(widths[i], dat_pat, m_cnt, user_pat);
                    if (m_pend) word[widths[i]-1] = ~word[widths[i]-1];
                    if (invert) word = word ^ ((32'd1 << widths[i]) - 32'd1);
                    e_out[i] = word;
                    e_ss[i]  = model_ss(widths[i], dat_pat, m_cnt);
                end
            end
            if (stb) begin
                m_cnt  = m_cnt + 1;
                m_pend = 1'b0;
            end
            if (!data_clock) m_guard = 1'b0;
            m_prev = data_clock;
            m_pat  = dat_pat;
        end
        exp_out = {e_out[2][7:0], e_out[1][3:0], e_out[0][0]};
        exp_vs  = {e_valid, e_valid, e_valid, e_ss[2], e_ss[1], e_ss[0]};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_clock = 1'b0; enable = 1'b1; invert = 1'b0; err_inj = 1'b0;
        dat_pat = 4'd3; user_pat = 16'h0000;
        for (int c = 0; c < 3; c++) cycle();
        if (act_out !== 13'd0) begin n_bad++; $display("[TB] FAIL reset_data_out: got %h expected 0", act_out); end
        n_cmp++;
        if (act_vs !== 6'd0) begin n_bad++; $display("[TB] FAIL reset_valid_sstart: got %b expected 0", act_vs); end
        n_cmp++;
        if (act_lfsr !== {3{31'h0000007F}}) begin
            n_bad++; $display("[TB] FAIL reset_lfsr: got %h expected three copies of 7f", act_lfsr);
        end
        n_cmp++;
        rst = 1'b0;
        cycle();
        if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL reset_release: got %b expected %b", act_vs, exp_vs); end
        n_cmp++;
    endtask

    task automatic test_prbs7();
        logic [6:0] first7;
        int nb, nss, ss0, ss1;
        nb = 0; nss = 0; ss0 = -1; ss1 = -1; first7 = '0;
        for (int c = 0; c < 260; c++) begin
            data_clock = (c % 2 == 0);
            cycle();
            if (act_out !== exp_out) begin n_bad++; $display("[TB] FAIL prbs7_out c=%0d: got %h expected %h", c, act_out, exp_out); end
            n_cmp++;
            if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL prbs7_vs c=%0d: got %b expected %b", c, act_vs, exp_vs); end
            n_cmp++;
            if (c % 2 == 0) begin
                if (nb < 7) first7[6-nb] = out1[0];
                if (s1) begin
                    if (nss == 0) ss0 = nb; else ss1 = nb;
                    nss++;
                end
                nb++;
            end
        end
        if (first7 !== 7'b0000001) begin n_bad++; $display("[TB] FAIL prbs7_first7: got %b expected 0000001", first7); end
        n_cmp++;
        if (nss != 2 || ss0 != 0 || ss1 != 127) begin
            n_bad++; $display("[TB] FAIL prbs7_seq_start: got count %0d at %0d,%0d expected 2 at 0,127", nss, ss0, ss1);
        end
        n_cmp++;
    endtask

    task automatic test_user();
        dat_pat = 4'd8; user_pat = 16'hA5C3;
        for (int c = 0; c < 24; c++) begin
            data_clock = (c % 2 == 0);
            cycle();
            if (act_out !== exp_out) begin n_bad++; $display("[TB] FAIL user_out c=%0d: got %h expected %h", c, act_out, exp_out); end
            n_cmp++;
            if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL user_vs c=%0d: got %b expected %b", c, act_vs, exp_vs); end
            n_cmp++;
            if (c % 2 == 0 && out8 !== ((c % 4 == 0) ? 8'hA5 : 8'hC3)) begin
                n_bad++; $display("[TB] FAIL user_word c=%0d: got %h expected %h", c, out8, (c % 4 == 0) ? 8'hA5 : 8'hC3);
            end
            n_cmp++;
        end
    endtask

    task automatic test_alt_invert();
        invert = 1'b1; dat_pat = 4'd2;
        for (int c = 0; c < 16; c++) begin
            data_clock = (c % 2 == 0);
            cycle();
            if (act_out !== exp_out) begin n_bad++; $display("[TB] FAIL alt_out c=%0d: got %h expected %h", c, act_out, exp_out); end
            n_cmp++;
            if (c % 2 == 0 && out1 !== 1'((c / 2) % 2)) begin
                n_bad++; $display("[TB] FAIL alt_bit c=%0d: got %b expected %0d", c, out1, (c / 2) % 2);
            end
            n_cmp++;
        end
        dat_pat = 4'd1;
        for (int c = 0; c < 8; c++) begin
            data_clock = (c % 2 == 0);
            cycle();
            if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL ones_vs c=%0d: got %b expected %b", c, act_vs, exp_vs); end
            n_cmp++;
            if (act_out !== 13'd0) begin n_bad++; $display("[TB] FAIL ones_inverted c=%0d: got %h expected 0", c, act_out); end
            n_cmp++;
        end
        invert = 1'b0;
    endtask

    task automatic test_err_inj();
        logic [3:0] gold;
        dat_pat = 4'd5;
        for (int c = 0; c < 60; c++) begin
            data_clock = (c % 2 == 0);
            err_inj    = (c == 19) || (c == 35) || (c == 36) || (c == 50);
            cycle();
            if (act_out !== exp_out) begin n_bad++; $display("[TB] FAIL err_out c=%0d: got %h expected %h", c, act_out, exp_out); end
            n_cmp++;
            if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL err_vs c=%0d: got %b expected %b", c, act_vs, exp_vs); end
            n_cmp++;
            if (c == 20 || c == 22) begin
                for (int k = 0; k < 4; k++) gold[3-k] = prbs_seq[2][(c / 2) * 4 + k];
                if (c == 20) gold[3] = ~gold[3];
                if (out4 !== gold) begin n_bad++; $display("[TB] FAIL err_word%0d: got %h expected %h", c / 2 + 1, out4, gold); end
                n_cmp++;
            end
        end
        err_inj = 1'b0;
    endtask

    task automatic test_enable();
        logic [92:0] exp_lfsr;
        dat_pat = 4'd7;
        for (int c = 0; c < 30; c++) begin
            enable     = !(c >= 10 && c < 20);
            data_clock = (c % 2 == 0);
            err_inj    = (c == 13);
            cycle();
            exp_lfsr = {model_lfsr(8, dat_pat, m_cnt), model_lfsr(4, dat_pat, m_cnt), model_lfsr(1, dat_pat, m_cnt)};
            if (act_lfsr !== exp_lfsr) begin n_bad++; $display("[TB] FAIL enable_lfsr c=%0d: got %h expected %h", c, act_lfsr, exp_lfsr); end
            n_cmp++;
            if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL enable_vs c=%0d: got %b expected %b", c, act_vs, exp_vs); end
            n_cmp++;
            if (act_out !== exp_out) begin n_bad++; $display("[TB] FAIL enable_out c=%0d: got %h expected %h", c, act_out, exp_out); end
            n_cmp++;
        end
        enable = 1'b1; err_inj = 1'b0;
    endtask

    task automatic test_reset_dc_high();
        int nvalid;
        nvalid = 0;
        data_clock = 1'b1; rst = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            data_clock = !(c == 3 || c >= 5);
            cycle();
            if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL rstdc_vs c=%0d: got %b expected %b", c, act_vs, exp_vs); end
            n_cmp++;
            if (act_out !== exp_out) begin n_bad++; $display("[TB] FAIL rstdc_out c=%0d: got %h expected %h", c, act_out, exp_out); end
            n_cmp++;
            if (v1) nvalid++;
        end
        if (nvalid != 1) begin n_bad++; $display("[TB] FAIL rstdc_count: got %0d valid pulses expected 1", nvalid); end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [3:0]  np;
        logic [92:0] exp_lfsr;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                do np = 4'($urandom % 16); while (np == dat_pat);
                dat_pat  = np;
                user_pat = 16'($urandom);
            end
            if (c % 64 == 0) invert = 1'($urandom % 2);
            data_clock = 1'($urandom % 2);
            enable     = ($urandom % 8) != 0;
            err_inj    = ($urandom % 10) == 0;
            cycle();
            if (act_out !== exp_out) begin n_bad++; $display("[TB] FAIL rand_out c=%0d mode=%0d: got %h expected %h", c, dat_pat, act_out, exp_out); end
            n_cmp++;
            if (act_vs !== exp_vs) begin n_bad++; $display("[TB] FAIL rand_vs c=%0d mode=%0d: got %b expected %b", c, dat_pat, act_vs, exp_vs); end
            n_cmp++;
            if (dat_pat >= 4'd3 && dat_pat != 4'd8) begin
                exp_lfsr = {model_lfsr(8, dat_pat, m_cnt), model_lfsr(4, dat_pat, m_cnt), model_lfsr(1, dat_pat, m_cnt)};
                if (act_lfsr !== exp_lfsr) begin n_bad++; $display("[TB] FAIL rand_lfsr c=%0d mode=%0d: got %h expected %h", c, dat_pat, act_lfsr, exp_lfsr); end
                n_cmp++;
            end
        end
        enable = 1'b1; err_inj = 1'b0; invert = 1'b0; data_clock = 1'b0;
    endtask

    initial begin
        init_prbs();
        test_reset();
        test_prbs7();
        test_user();
        test_alt_invert();
        test_err_inj();
        test_enable();
        test_reset_dc_high();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
